commit_aggregator_multi: RTL

- Generalised commit aggregator between the MPU issue path and the TPU array.
- Tracks up to DEPTH in-flight thread issues.
- Per issue, records which TPUs were enabled and collects per-TPU commit pulses.
- Once every enabled TPU has committed, returns the issue number to the MPU, strictly in issue order, over a valid/ready handshake.

---
 rtl/commit_aggregator_multi_if.sv | 30 +++
 rtl/commit_aggregator_multi.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/commit_aggregator_multi_if.sv
// Issue / commit handshake bundle between the MPU, the TPU array and commit_aggregator_multi.
interface commit_aggregator_multi_if #(
  parameter int NUM_TPUS    = 4,
  parameter int DEPTH       = 4,
  parameter int WIDTH_ISSUE = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                            I_Issue_Valid;
  logic [WIDTH_ISSUE-1:0]          I_Issue_No;
  logic [NUM_TPUS-1:0]             I_En_TPU;
  logic                            O_Issue_Ready;
  logic [NUM_TPUS-1:0]             I_Commit;
  logic [NUM_TPUS*WIDTH_ISSUE-1:0] I_Commit_No;
  logic                            O_Commit_Valid;
  logic [WIDTH_ISSUE-1:0]          O_Commit_No;
  logic                            I_Commit_Ready;
  logic [CW-1:0]                   O_Count;
  logic                            O_Err;

  modport master (
    output I_Issue_Valid, I_Issue_No, I_En_TPU, I_Commit, I_Commit_No, I_Commit_Ready,
    input  O_Issue_Ready, O_Commit_Valid, O_Commit_No, O_Count, O_Err
  );

  modport slave (
    input  I_Issue_Valid, I_Issue_No, I_En_TPU, I_Commit, I_Commit_No, I_Commit_Ready,
    output O_Issue_Ready, O_Commit_Valid, O_Commit_No, O_Count, O_Err
  );
endinterface

// File: rtl/commit_aggregator_multi.sv
// In-order commit aggregator: tracks DEPTH issues, gathers per-TPU commits, returns issue numbers in order.
// Define COMMIT_AGG_TIMEOUT_EN to add the head-entry age watchdog (O_Timeout / O_Missing).
module commit_aggregator_multi #(
  parameter int NUM_TPUS       = 4,
  parameter int DEPTH          = 4,
  parameter int WIDTH_ISSUE    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  commit_aggregator_multi_if.slave  bus
`ifdef COMMIT_AGG_TIMEOUT_EN
  ,
  output logic                      O_Timeout,
  output logic [NUM_TPUS-1:0]       O_Missing
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("commit_aggregator_multi: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic                   v_q  [DEPTH];
  logic                   v_d  [DEPTH];
  logic [WIDTH_ISSUE-1:0] no_q [DEPTH];
  logic [WIDTH_ISSUE-1:0] no_d [DEPTH];
  logic [NUM_TPUS-1:0]    en_q [DEPTH];
  logic [NUM_TPUS-1:0]    en_d [DEPTH];
  logic [NUM_TPUS-1:0]    cm_q [DEPTH];
  logic [NUM_TPUS-1:0]    cm_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   err_q, err_d;
  logic                   issue_ready, head_done, accept, pop, found;
  logic [NUM_TPUS-1:0]    new_cm;
  logic [PW-1:0]          idx;

  assign issue_ready        = (count_q < CW'(DEPTH));
  assign head_done          = v_q[rd_ptr_q] && (cm_q[rd_ptr_q] == en_q[rd_ptr_q]);
  assign accept             = bus.I_Issue_Valid && issue_ready;
  assign pop                = head_done && bus.I_Commit_Ready;

  assign bus.O_Issue_Ready  = issue_ready;
  assign bus.O_Commit_Valid = head_done;
  assign bus.O_Commit_No    = v_q[rd_ptr_q] ? no_q[rd_ptr_q] : '0;
  assign bus.O_Count        = count_q;
  assign bus.O_Err          = err_q;

  always_comb begin
    v_d    = v_q;
    no_d   = no_q;
    en_d   = en_q;
    cm_d   = cm_q;
    err_d  = err_q;
    new_cm = '0;
    idx    = '0;
    found  = 1'b0;
    // Oldest matching entry wins; the entry being allocated this cycle is the youngest candidate.
    for (int k = 0; k < NUM_TPUS; k++) begin
      if (bus.I_Commit[k]) begin
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          idx = rd_ptr_q + PW'(i);
          if (!found && v_q[idx] && en_q[idx][k] &&
              (no_q[idx] == bus.I_Commit_No[k*WIDTH_ISSUE +: WIDTH_ISSUE])) begin
            cm_d[idx][k] = 1'b1;
            found        = 1'b1;
          end
        end
        if (!found && accept && bus.I_En_TPU[k] &&
            (bus.I_Issue_No == bus.I_Commit_No[k*WIDTH_ISSUE +: WIDTH_ISSUE])) begin
          new_cm[k] = 1'b1;
          found     = 1'b1;
        end
        if (!found) err_d = 1'b1;
      end
    end
    if (pop) begin
      v_d[rd_ptr_q]  = 1'b0;
      no_d[rd_ptr_q] = '0;
      en_d[rd_ptr_q] = '0;
      cm_d[rd_ptr_q] = '0;
    end
    if (accept) begin
      v_d[wr_ptr_q]  = 1'b1;
      no_d[wr_ptr_q] = bus.I_Issue_No;
      en_d[wr_ptr_q] = bus.I_En_TPU;
      cm_d[wr_ptr_q] = new_cm;
    end
    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i]  <= 1'b0;
        no_q[i] <= '0;
        en_q[i] <= '0;
        cm_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      v_q      <= v_d;
      no_q     <= no_d;
      en_q     <= en_d;
      cm_q     <= cm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

`ifdef COMMIT_AGG_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [AW-1:0]       age_q, age_d;
  logic                to_q, to_d;
  logic [NUM_TPUS-1:0] miss_q, miss_d;

  // Age saturates at the limit so a stuck head reports exactly once.
  always_comb begin
    age_d  = age_q;
    to_d   = 1'b0;
    miss_d = miss_q;
    if (pop) begin
      age_d = '0;
    end else if (v_q[rd_ptr_q] && !head_done && (age_q != AW'(TIMEOUT_CYCLES))) begin
      age_d = age_q + AW'(1);
      if (age_d == AW'(TIMEOUT_CYCLES)) begin
        to_d   = 1'b1;
        miss_d = en_q[rd_ptr_q] & ~cm_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age_q  <= '0;
      to_q   <= 1'b0;
      miss_q <= '0;
    end else begin
      age_q  <= age_d;
      to_q   <= to_d;
      miss_q <= miss_d;
    end
  end

  assign O_Timeout = to_q;
  assign O_Missing = miss_q;
`endif
endmodule
